csr_access_seq: RTL and testbench
=================================

# csr_access_seq

Multi-cycle sequencer between instruction decode and the CSR unit (`crs_unit`). It accepts one SYSTEM-opcode CSR instruction per transaction and translates funct3 into the CSR unit's op encoding. It drives a single-cycle access to the CSR unit, captures the registered read value, and returns it to the register file through a valid/ready write-back port. Illegal encodings and write-suppression cases are resolved here, so the CSR unit only ever sees well-formed accesses.

## Interface
Parameters:
- `REG_XLEN`, 32: register and CSR data width.
- `CSR_ADDR_WIDTH`, 12: CSR address width.
- `CSR_OP_WIDTH`, 3: width of the CSR op code.
- `REG_ADDR_WIDTH`, 5: register index width.

Ports:
- `clk`  in  1: single clock; all state changes on its rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `instr_valid_i`  in  1: decode presents a CSR instruction.
- `instr_ready_o`  out  1: sequencer can accept an instruction.
- `instr_i`  in  32: full instruction word.
- `rs1_val_i`  in  REG_XLEN: rs1 operand; sampled on accept.
- `csr_addr_o`  out  CSR_ADDR_WIDTH: to CSR unit `csr_addr_i`.
- `csr_op_o`  out  CSR_OP_WIDTH: to CSR unit `csr_op_i`; 0 = no access.
- `csr_wdata_o`  out  REG_XLEN: to CSR unit `csr_val_i`.
- `csr_rdata_i`  in  REG_XLEN: from CSR unit `csr_val_o`.
- `rd_we_o`  out  1: write-back valid.
- `rd_addr_o`  out  REG_ADDR_WIDTH: destination register index.
- `rd_data_o`  out  REG_XLEN: old CSR value.
- `rd_ready_i`  in  1: register file accepts the write-back.
- `illegal_o`  out  1: one-cycle pulse for a rejected instruction.

## Operation
- States: IDLE, ISSUE, WAIT, WB, ERR.
- **IDLE**
  - `instr_ready_o` = 1; all other outputs are 0.
  - An accept (`instr_valid_i` & `instr_ready_o`) latches addr = `instr_i[31:20]`, rd = `[11:7]`, rs1/zimm = `[19:15]`, funct3 = `[14:12]`, and `rs1_val_i`.
- **Decode checks, applied at accept**
  - The instruction is illegal if opcode `instr_i[6:0]` != 7'b1110011, or if funct3 is 000 or 100.
  - An illegal instruction moves to ERR; otherwise the sequencer moves to ISSUE.
- **funct3 to op mapping**
  - 001→1 (CSRRW), 010→2 (CSRRS), 011→3 (CSRRC).
  - 101→4 (CSRRWI), 110→5 (CSRRSI), 111→6 (CSRRCI).
- **Write operand**
  - Register forms send the latched rs1 value.
  - Immediate forms send zimm zero-extended to REG_XLEN.
- **Write suppression**
  - For RS/RC/RSI/RCI with rs1/zimm field = 0, `csr_wdata_o` = 0. The CSR unit treats this as read-only.
- **ISSUE**: drives `csr_op_o`, `csr_addr_o` and `csr_wdata_o` for exactly one cycle, then goes to WAIT.
- **WAIT**
  - `csr_op_o` = 0.
  - `csr_rdata_i` is captured into the rd data register at the end of the cycle.
  - Next state is WB if rd != 0, otherwise IDLE (read result discarded).
- **WB**
  - `rd_we_o` = 1 with a stable `rd_addr_o`/`rd_data_o`.
  - Holds until `rd_ready_i` = 1, then returns to IDLE.
- **ERR**: `illegal_o` = 1 for one cycle, then IDLE. No CSR access is issued and no write-back occurs.

## Timing
- Reset values: IDLE; `instr_ready_o`=0 while `rst_n`=0 (1 after release); `csr_op_o`=0, `csr_addr_o`=0, `csr_wdata_o`=0, `rd_we_o`=0, `rd_addr_o`=0, `rd_data_o`=0, `illegal_o`=0.
- Latency: accept at edge N; `csr_op_o` != 0 in cycle N+1; `rd_we_o` first high in cycle N+3.
- Minimum occupancy: 3 cycles with rd=0, 4 cycles with immediate `rd_ready_i`, 2 cycles for an illegal instruction.
- Back-to-back: `instr_ready_o` is high only in IDLE, so the next accept occurs in the cycle after the return to IDLE.
- `rd_ready_i` low: WB stalls indefinitely and outputs hold. `instr_i`/`rs1_val_i` changes after accept are ignored.
- Reset mid-transaction (including in ISSUE):
  - `csr_op_o` drops to 0 asynchronously.
  - The pending write-back is dropped, and no `illegal_o` pulse is produced.

## Configuration
- `CSR_SEQ_RO_CHECK_EN`
  - **Defined**: an access with `addr[11:10]`=2'b11 (read-only space, e.g. 0xC00–0xC82) that would write is illegal and goes to ERR. "Would write" means CSRRW/CSRRWI always, or RS/RC/RSI/RCI with a nonzero rs1/zimm field.
  - **Undefined**: no address-space check; the access is issued to the CSR unit unchanged.

## Structure
- The shared defines header holds:
  - The SYSTEM opcode constant.
  - The CSR op codes (1–6, 0 = none).
  - The state encoding.
  - `CSR_OP_WIDTH`/`CSR_ADDR_WIDTH`.
- One natural sub-module, `csr_instr_decode`: combinational funct3→op mapping, operand selection, and illegal/read-only flags. The FSM and registers stay in `csr_access_seq`.

## Test plan
- CSRRS x5, cycle (0xC00), rs1=x0; CSR unit returns 0x0000_0123 → one access with op=2, addr=0xC00, wdata=0; `rd_we_o`=1, rd=5, data=0x0000_0123 in cycle N+3.
- CSRRWI x0, 0x340, zimm=0x1F → op=4, wdata=0x0000_001F; no `rd_we_o`; `instr_ready_o` high again in cycle N+3.
- funct3=100 and opcode 0110011 → `illegal_o` pulses once each; `csr_op_o` stays 0.
- With `CSR_SEQ_RO_CHECK_EN`: CSRRW x1, 0xC80 → illegal, no access. Without the macro → access issued with op=1.
- `rd_ready_i` held low 5 cycles during WB → `rd_we_o`/`rd_data_o` stable, `instr_ready_o`=0; exit on the first high cycle.
- `rst_n` asserted during ISSUE → `csr_op_o`=0 immediately and all outputs at reset values; a new CSRRS is accepted correctly after release.

Source files
------------

// File: rtl/csr_access_seq_pkg.sv
// =============================================================================
// csr_access_seq_pkg : shared constants, op codes and state encoding
// Revision: 1.0
// =============================================================================
`default_nettype none

package csr_access_seq_pkg;

  localparam int c_CSR_OP_WIDTH   = 3;
  localparam int c_CSR_ADDR_WIDTH = 12;

  localparam logic [6:0] c_OPCODE_SYSTEM = 7'b1110011;

  localparam logic [c_CSR_OP_WIDTH-1:0] c_OP_NONE = 3'd0;
  localparam logic [c_CSR_OP_WIDTH-1:0] c_OP_RW   = 3'd1;
  localparam logic [c_CSR_OP_WIDTH-1:0] c_OP_RS   = 3'd2;
  localparam logic [c_CSR_OP_WIDTH-1:0] c_OP_RC   = 3'd3;
  localparam logic [c_CSR_OP_WIDTH-1:0] c_OP_RWI  = 3'd4;
  localparam logic [c_CSR_OP_WIDTH-1:0] c_OP_RSI  = 3'd5;
  localparam logic [c_CSR_OP_WIDTH-1:0] c_OP_RCI  = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_WB    = 3'd3,
    S_ERR   = 3'd4
  } seq_state_e;

endpackage

`default_nettype wire

// File: rtl/csr_instr_decode.sv
// =============================================================================
// csr_instr_decode : funct3->op mapping, write operand and illegal detection
// Optional: CSR_SEQ_RO_CHECK_EN rejects writes to the read-only CSR space.
// Revision: 1.0
// =============================================================================
`default_nettype none

module csr_instr_decode
  import csr_access_seq_pkg::*;
#(
  parameter int REG_XLEN = 32
) (
  input  logic [6:0]                i_opcode,
  input  logic [2:0]                i_funct3,
  input  logic [4:0]                i_zimm,
  input  logic [1:0]                i_addr_hi,
  input  logic [REG_XLEN-1:0]       i_rs1_val,
  output logic [c_CSR_OP_WIDTH-1:0] o_op,
  output logic [REG_XLEN-1:0]       o_wdata,
  output logic                      o_illegal
);

  logic w_bad_f3;
  logic w_writes;
  logic w_bad_opcode;

  always_comb begin
    o_op     = c_OP_NONE;
    w_bad_f3 = 1'b0;
    case (i_funct3)
      3'b001:  o_op = c_OP_RW;
      3'b010:  o_op = c_OP_RS;
      3'b011:  o_op = c_OP_RC;
      3'b101:  o_op = c_OP_RWI;
      3'b110:  o_op = c_OP_RSI;
      3'b111:  o_op = c_OP_RCI;
      default: w_bad_f3 = 1'b1;
    endcase
  end

  // Set/clear forms with a zero source field must not modify the CSR.
  assign w_writes     = (i_funct3[1:0] == 2'b01) || (i_zimm != 5'd0);
  assign w_bad_opcode = (i_opcode != c_OPCODE_SYSTEM);

  always_comb begin
    o_wdata = '0;
    if (w_writes) begin
      o_wdata = i_funct3[2] ? REG_XLEN'(i_zimm) : i_rs1_val;
    end
  end

`ifdef CSR_SEQ_RO_CHECK_EN
  logic w_ro_write;
  assign w_ro_write = (&i_addr_hi) && w_writes;
  assign o_illegal  = w_bad_opcode || w_bad_f3 || w_ro_write;
`else
  logic w_unused_addr_hi;
  assign w_unused_addr_hi = ^i_addr_hi;
  assign o_illegal        = w_bad_opcode || w_bad_f3;
`endif

endmodule

`default_nettype wire

// File: rtl/csr_access_seq.sv
// =============================================================================
// csr_access_seq : decode -> CSR unit access -> register write-back sequencer
// Optional: CSR_SEQ_RO_CHECK_EN (read-only space write check, in decoder).
// Revision: 1.0
// =============================================================================
`default_nettype none

module csr_access_seq
  import csr_access_seq_pkg::*;
#(
  parameter int REG_XLEN       = 32,
  parameter int CSR_ADDR_WIDTH = 12,
  parameter int CSR_OP_WIDTH   = 3,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      instr_valid_i,
  output logic                      instr_ready_o,
  input  logic [31:0]               instr_i,
  input  logic [REG_XLEN-1:0]       rs1_val_i,
  output logic [CSR_ADDR_WIDTH-1:0] csr_addr_o,
  output logic [CSR_OP_WIDTH-1:0]   csr_op_o,
  output logic [REG_XLEN-1:0]       csr_wdata_o,
  input  logic [REG_XLEN-1:0]       csr_rdata_i,
  output logic                      rd_we_o,
  output logic [REG_ADDR_WIDTH-1:0] rd_addr_o,
  output logic [REG_XLEN-1:0]       rd_data_o,
  input  logic                      rd_ready_i,
  output logic                      illegal_o
);

  seq_state_e                r_state;
  logic [REG_ADDR_WIDTH-1:0] r_rd;
  logic [CSR_OP_WIDTH-1:0]   r_csr_op;
  logic [CSR_ADDR_WIDTH-1:0] r_csr_addr;
  logic [REG_XLEN-1:0]       r_csr_wdata;
  logic                      r_rd_we;
  logic [REG_ADDR_WIDTH-1:0] r_rd_addr;
  logic [REG_XLEN-1:0]       r_rd_data;
  logic                      r_illegal;

  logic [c_CSR_OP_WIDTH-1:0] w_op;
  logic [REG_XLEN-1:0]       w_wdata;
  logic                      w_illegal;
  logic                      w_accept;

  csr_instr_decode #(
    .REG_XLEN (REG_XLEN)
  ) u_decode (
    .i_opcode  (instr_i[6:0]),
    .i_funct3  (instr_i[14:12]),
    .i_zimm    (instr_i[19:15]),
    .i_addr_hi (instr_i[31:30]),
    .i_rs1_val (rs1_val_i),
    .o_op      (w_op),
    .o_wdata   (w_wdata),
    .o_illegal (w_illegal)
  );

  // Ready is gated by reset so it reads 0 while the block is held in reset.
  assign instr_ready_o = rst_n && (r_state == S_IDLE);
  assign w_accept      = instr_valid_i && instr_ready_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_rd        <= '0;
      r_csr_op    <= '0;
      r_csr_addr  <= '0;
      r_csr_wdata <= '0;
      r_rd_we     <= 1'b0;
      r_rd_addr   <= '0;
      r_rd_data   <= '0;
      r_illegal   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_rd <= REG_ADDR_WIDTH'(instr_i[11:7]);
            if (w_illegal) begin
              r_illegal <= 1'b1;
              r_state   <= S_ERR;
            end else begin
              r_csr_op    <= CSR_OP_WIDTH'(w_op);
              r_csr_addr  <= CSR_ADDR_WIDTH'(instr_i[31:20]);
              r_csr_wdata <= w_wdata;
              r_state     <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          r_csr_op    <= '0;
          r_csr_addr  <= '0;
          r_csr_wdata <= '0;
          r_state     <= S_WAIT;
        end
        S_WAIT: begin
          // A read into x0 is discarded so that idle outputs remain zero.
          if (r_rd != '0) begin
            r_rd_we   <= 1'b1;
            r_rd_addr <= r_rd;
            r_rd_data <= csr_rdata_i;
            r_state   <= S_WB;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_WB: begin
          if (rd_ready_i) begin
            r_rd_we   <= 1'b0;
            r_rd_addr <= '0;
            r_rd_data <= '0;
            r_state   <= S_IDLE;
          end
        end
        S_ERR: begin
          r_illegal <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign csr_op_o    = r_csr_op;
  assign csr_addr_o  = r_csr_addr;
  assign csr_wdata_o = r_csr_wdata;
  assign rd_we_o     = r_rd_we;
  assign rd_addr_o   = r_rd_addr;
  assign rd_data_o   = r_rd_data;
  assign illegal_o   = r_illegal;

endmodule

`default_nettype wire

// File: tb/tb_csr_access_seq.sv
// =============================================================================
// tb_csr_access_seq : self-checking bench for csr_access_seq
// Revision: 1.0
// =============================================================================
`default_nettype none

module tb_csr_access_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid_i = 1'b0;
  logic        instr_ready_o;
  logic [31:0] instr_i = '0;
  logic [31:0] rs1_val_i = '0;
  logic [11:0] csr_addr_o;
  logic [2:0]  csr_op_o;
  logic [31:0] csr_wdata_o;
  logic [31:0] csr_rdata_i = '0;
  logic        rd_we_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_data_o;
  logic        rd_ready_i = 1'b1;
  logic        illegal_o;

  int n_cmp  = 0;
  int n_fail = 0;

  csr_access_seq dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .instr_valid_i (instr_valid_i),
    .instr_ready_o (instr_ready_o),
    .instr_i       (instr_i),
    .rs1_val_i     (rs1_val_i),
    .csr_addr_o    (csr_addr_o),
    .csr_op_o      (csr_op_o),
    .csr_wdata_o   (csr_wdata_o),
    .csr_rdata_i   (csr_rdata_i),
    .rd_we_o       (rd_we_o),
    .rd_addr_o     (rd_addr_o),
    .rd_data_o     (rd_data_o),
    .rd_ready_i    (rd_ready_i),
    .illegal_o     (illegal_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [11:0] addr, input logic [4:0] zimm,
                                     input logic [2:0] f3, input logic [4:0] rd,
                                     input logic [6:0] opc);
    return {addr, zimm, f3, rd, opc};
  endfunction

  // Reference: the architectural meaning of a CSR instruction.
  function automatic void model(input logic [31:0] ins, input logic [31:0] rs1,
                                output bit ill, output logic [2:0] op,
                                output logic [31:0] wd);
    int  f3;
    int  z;
    bit  writes;
    f3     = int'(ins[14:12]);
    z      = int'(ins[19:15]);
    ill    = (ins[6:0] != 7'h73) || (f3 == 0) || (f3 == 4);
    op     = (f3 >= 5) ? 3'(f3 - 1) : 3'(f3);
    writes = ((f3 % 4) == 1) || (z != 0);
    if (!writes)      wd = 32'd0;
    else if (f3 >= 4) wd = 32'(z);
    else              wd = rs1;
`ifdef CSR_SEQ_RO_CHECK_EN
    if (ins[31:30] == 2'b11 && writes) ill = 1'b1;
`endif
  endfunction

  task automatic do_txn(input logic [31:0] ins, input logic [31:0] rs1,
                        input logic [31:0] rdata, input int stall);
    bit          ill;
    logic [2:0]  op;
    logic [31:0] wd;
    logic [4:0]  rd;
    model(ins, rs1, ill, op, wd);
    rd = ins[11:7];
    @(negedge clk);
    n_cmp++;
    if (instr_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL ready_idle: got %b expected 1", instr_ready_o);
    end
    instr_valid_i = 1'b1; instr_i = ins; rs1_val_i = rs1; rd_ready_i = 1'b1;
    @(negedge clk);  // cycle N+1
    instr_valid_i = 1'b0; instr_i = $urandom; rs1_val_i = $urandom;
    if (ill) begin
      n_cmp++;
      if ({illegal_o, csr_op_o, instr_ready_o, rd_we_o} !== {1'b1, 3'd0, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL err_cycle ins=%h: got ill=%b op=%0d rdy=%b we=%b expected ill=1 op=0 rdy=0 we=0",
                 ins, illegal_o, csr_op_o, instr_ready_o, rd_we_o);
      end
      @(negedge clk);
      n_cmp++;
      if ({illegal_o, instr_ready_o, csr_op_o} !== {1'b0, 1'b1, 3'd0}) begin
        n_fail++;
        $display("FAIL err_exit: got ill=%b rdy=%b op=%0d expected ill=0 rdy=1 op=0",
                 illegal_o, instr_ready_o, csr_op_o);
      end
      return;
    end
    n_cmp++;
    if ({csr_op_o, csr_addr_o, csr_wdata_o, instr_ready_o, rd_we_o} !==
        {op, ins[31:20], wd, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL issue ins=%h: got op=%0d addr=%h wd=%h rdy=%b we=%b expected op=%0d addr=%h wd=%h rdy=0 we=0",
               ins, csr_op_o, csr_addr_o, csr_wdata_o, instr_ready_o, rd_we_o, op, ins[31:20], wd);
    end
    csr_rdata_i = rdata;
    @(negedge clk);  // cycle N+2
    n_cmp++;
    if ({csr_op_o, rd_we_o, instr_ready_o} !== {3'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL wait: got op=%0d we=%b rdy=%b expected op=0 we=0 rdy=0",
               csr_op_o, rd_we_o, instr_ready_o);
    end
    @(negedge clk);  // cycle N+3
    csr_rdata_i = $urandom;
    if (rd == 5'd0) begin
      n_cmp++;
      if ({instr_ready_o, rd_we_o, rd_data_o} !== {1'b1, 1'b0, 32'd0}) begin
        n_fail++;
        $display("FAIL rd0_done: got rdy=%b we=%b data=%h expected rdy=1 we=0 data=0",
                 instr_ready_o, rd_we_o, rd_data_o);
      end
      return;
    end
    n_cmp++;
    if ({rd_we_o, rd_addr_o, rd_data_o, instr_ready_o} !== {1'b1, rd, rdata, 1'b0}) begin
      n_fail++;
      $display("FAIL wb: got we=%b rd=%0d data=%h rdy=%b expected we=1 rd=%0d data=%h rdy=0",
               rd_we_o, rd_addr_o, rd_data_o, instr_ready_o, rd, rdata);
    end
    rd_ready_i = (stall == 0);
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({rd_we_o, rd_addr_o, rd_data_o, instr_ready_o} !== {1'b1, rd, rdata, 1'b0}) begin
        n_fail++;
        $display("FAIL wb_stall%0d: got we=%b rd=%0d data=%h rdy=%b expected we=1 rd=%0d data=%h rdy=0",
                 k, rd_we_o, rd_addr_o, rd_data_o, instr_ready_o, rd, rdata);
      end
      if (k == stall - 1) rd_ready_i = 1'b1;
    end
    @(negedge clk);
    n_cmp++;
    if ({rd_we_o, instr_ready_o, rd_data_o} !== {1'b0, 1'b1, 32'd0}) begin
      n_fail++;
      $display("FAIL wb_exit: got we=%b rdy=%b data=%h expected we=0 rdy=1 data=0",
               rd_we_o, instr_ready_o, rd_data_o);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({instr_ready_o, csr_op_o, csr_addr_o, csr_wdata_o, rd_we_o, rd_addr_o, rd_data_o, illegal_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_vals: got rdy=%b op=%0d addr=%h wd=%h we=%b rd=%0d data=%h ill=%b expected all 0",
               instr_ready_o, csr_op_o, csr_addr_o, csr_wdata_o, rd_we_o, rd_addr_o, rd_data_o, illegal_o);
    end
    #2 rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({instr_ready_o, illegal_o, rd_we_o, csr_op_o} !== {1'b1, 1'b0, 1'b0, 3'd0}) begin
      n_fail++;
      $display("FAIL reset_release: got rdy=%b ill=%b we=%b op=%0d expected rdy=1 ill=0 we=0 op=0",
               instr_ready_o, illegal_o, rd_we_o, csr_op_o);
    end
  endtask

  task automatic test_csrrs_read();
    do_txn(mk(12'hC00, 5'd0, 3'b010, 5'd5, 7'h73), $urandom, 32'h0000_0123, 0);
  endtask

  task automatic test_csrrwi_rd0();
    do_txn(mk(12'h340, 5'h1F, 3'b101, 5'd0, 7'h73), $urandom, $urandom, 0);
  endtask

  task automatic test_illegal();
    do_txn(mk(12'h300, 5'd3, 3'b100, 5'd4, 7'h73), $urandom, $urandom, 0);
    do_txn(mk(12'h300, 5'd3, 3'b001, 5'd4, 7'b0110011), $urandom, $urandom, 0);
    do_txn(mk(12'h305, 5'd1, 3'b000, 5'd2, 7'h73), $urandom, $urandom, 0);
  endtask

  task automatic test_ro_space();
    do_txn(mk(12'hC80, 5'd2, 3'b001, 5'd1, 7'h73), 32'hDEAD_BEEF, 32'h1234_5678, 0);
    do_txn(mk(12'hC81, 5'd0, 3'b011, 5'd9, 7'h73), 32'hFFFF_FFFF, 32'h0BAD_F00D, 0);
  endtask

  task automatic test_wb_stall();
    do_txn(mk(12'h341, 5'd7, 3'b011, 5'd12, 7'h73), 32'hA5A5_0F0F, 32'hCAFE_0001, 5);
  endtask

  task automatic test_reset_in_issue();
    @(negedge clk);
    instr_valid_i = 1'b1; instr_i = mk(12'h300, 5'd3, 3'b010, 5'd7, 7'h73); rs1_val_i = 32'h55;
    @(negedge clk);
    instr_valid_i = 1'b0;
    n_cmp++;
    if (csr_op_o !== 3'd2) begin
      n_fail++; $display("FAIL rst_pre_issue: got op=%0d expected 2", csr_op_o);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({instr_ready_o, csr_op_o, csr_addr_o, csr_wdata_o, rd_we_o, rd_addr_o, rd_data_o, illegal_o} !== '0) begin
      n_fail++;
      $display("FAIL rst_in_issue: got rdy=%b op=%0d addr=%h wd=%h we=%b rd=%0d data=%h ill=%b expected all 0",
               instr_ready_o, csr_op_o, csr_addr_o, csr_wdata_o, rd_we_o, rd_addr_o, rd_data_o, illegal_o);
    end
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({instr_ready_o, rd_we_o, illegal_o, csr_op_o} !== {1'b1, 1'b0, 1'b0, 3'd0}) begin
      n_fail++;
      $display("FAIL rst_after: got rdy=%b we=%b ill=%b op=%0d expected rdy=1 we=0 ill=0 op=0",
               instr_ready_o, rd_we_o, illegal_o, csr_op_o);
    end
    do_txn(mk(12'h300, 5'd3, 3'b010, 5'd7, 7'h73), 32'h0000_00F0, 32'h8000_0001, 0);
  endtask

  task automatic test_random();
    logic [11:0] addr;
    logic [4:0]  zimm;
    logic [4:0]  rd;
    logic [6:0]  opc;
    for (int i = 0; i < 60; i++) begin
      addr = ($urandom_range(0, 3) == 0) ? {2'b11, 10'($urandom)} : 12'($urandom);
      zimm = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      rd   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      opc  = ($urandom_range(0, 7) == 0) ? 7'($urandom) : 7'h73;
      do_txn(mk(addr, zimm, 3'($urandom), rd, opc), $urandom, $urandom, $urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset();
    test_csrrs_read();
    test_csrrwi_rd0();
    test_illegal();
    test_ro_space();
    test_wb_stall();
    test_reset_in_issue();
    test_random();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
